// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared state encoding, scale default and exact product helper
package approx_mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DIV,
        ST_DONE
    } state_t;

    localparam int RED_SCALE_DEFAULT = 10000;
    localparam int PROD_MAX_W        = 16;

    // Callers zero-extend operands up to PROD_MAX_W and truncate the result to 2W.
    function automatic logic [2*PROD_MAX_W-1:0] exact_prod(
        input logic [PROD_MAX_W-1:0] a,
        input logic [PROD_MAX_W-1:0] b
    );
        return (2*PROD_MAX_W)'(a) * (2*PROD_MAX_W)'(b);
    endfunction

endpackage

// File: rtl/approx_err_div.sv
// rtl/approx_err_div.sv - restoring unsigned divider, one quotient bit per cycle
module approx_err_div #(
    parameter int W     = 4,
    parameter int RED_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [RED_W-1:0]   dividend,
    input  logic [2*W-1:0]     divisor,
    output logic [RED_W-1:0]   quotient,
    output logic               div_done
);
    localparam int DW = 2 * W;
    localparam int CW = $clog2(RED_W);

    logic             run_q,  run_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic [DW-1:0]    rem_q,  rem_d;
    logic [DW-1:0]    dvs_q,  dvs_d;
    logic [RED_W-1:0] quo_q,  quo_d;
    logic             done_q, done_d;
    logic [DW:0]      trial;
    logic             fits;

    always_comb begin
        // quo_q shifts the dividend out at the top while quotient bits enter at the bottom
        trial  = {rem_q, quo_q[RED_W-1]};
        fits   = (trial >= {1'b0, dvs_q});
        run_d  = run_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        done_d = 1'b0;
        if (run_q) begin
            rem_d = fits ? DW'(trial - {1'b0, dvs_q}) : trial[DW-1:0];
            quo_d = {quo_q[RED_W-2:0], fits};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(RED_W - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end else if (go) begin
            run_d = 1'b1;
            cnt_d = '0;
            rem_d = '0;
            dvs_d = divisor;
            quo_d = dividend;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            done_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign div_done = done_q;

endmodule

// File: rtl/approx_mult_err_sweep.sv
// rtl/approx_mult_err_sweep.sv - exhaustive operand sweep and error metric accumulator
module approx_mult_err_sweep
    import approx_mult_pkg::*;
#(
    parameter int W         = 4,
    parameter int RED_SCALE = RED_SCALE_DEFAULT,
    parameter int RED_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    input  logic [2*W-1:0]     mul_r,
    output logic               busy,
    output logic               done,
    output logic               err_valid,
    output logic [W-1:0]       err_a,
    output logic [W-1:0]       err_b,
    output logic [2*W-1:0]     err_r,
    output logic [2*W:0]       err_cnt,
    output logic [2*W:0]       over_cnt,
    output logic [4*W-1:0]     ed_sum,
    output logic [2*W-1:0]     max_ed,
    output logic [RED_W-1:0]   red_sum
);
    localparam int PW = 2 * W;

    state_t           state_q,     state_d;
    logic [W-1:0]     a_q,         a_d;
    logic [W-1:0]     b_q,         b_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             err_valid_q, err_valid_d;
    logic [W-1:0]     err_a_q,     err_a_d;
    logic [W-1:0]     err_b_q,     err_b_d;
    logic [PW-1:0]    err_r_q,     err_r_d;
    logic [PW:0]      err_cnt_q,   err_cnt_d;
    logic [PW:0]      over_cnt_q,  over_cnt_d;
    logic [4*W-1:0]   ed_sum_q,    ed_sum_d;
    logic [PW-1:0]    max_ed_q,    max_ed_d;
    logic [RED_W-1:0] red_sum_q,   red_sum_d;

    logic [PW-1:0]    exact;
    logic             over;
    logic [PW-1:0]    ed;
    logic             div_go;
    logic [RED_W-1:0] dividend;
    logic [RED_W-1:0] quotient;
    logic             div_done;
    logic             advance;

    assign exact    = PW'(exact_prod(PROD_MAX_W'(a_q), PROD_MAX_W'(b_q)));
    assign over     = (mul_r > exact);
    assign ed       = over ? (mul_r - exact) : (exact - mul_r);
    assign div_go   = (state_q == ST_SAMPLE) && (ed != '0) && (exact != '0);
    assign dividend = RED_W'(ed) * RED_W'(RED_SCALE);

    approx_err_div #(.W(W), .RED_W(RED_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (div_go),
        .dividend (dividend),
        .divisor  (exact),
        .quotient (quotient),
        .div_done (div_done)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_valid_d = 1'b0;
        err_a_d     = err_a_q;
        err_b_d     = err_b_q;
        err_r_d     = err_r_q;
        err_cnt_d   = err_cnt_q;
        over_cnt_d  = over_cnt_q;
        ed_sum_d    = ed_sum_q;
        max_ed_d    = max_ed_q;
        red_sum_d   = red_sum_q;
        advance     = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d    = ST_DRIVE;
                busy_d     = 1'b1;
                a_d        = '0;
                b_d        = '0;
                err_cnt_d  = '0;
                over_cnt_d = '0;
                ed_sum_d   = '0;
                max_ed_d   = '0;
                red_sum_d  = '0;
            end
            ST_DRIVE: state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (ed != '0) begin
                    err_cnt_d   = err_cnt_q + (PW+1)'(1);
                    over_cnt_d  = over ? over_cnt_q + (PW+1)'(1) : over_cnt_q;
                    ed_sum_d    = ed_sum_q + (4*W)'(ed);
                    max_ed_d    = (ed > max_ed_q) ? ed : max_ed_q;
                    err_valid_d = 1'b1;
                    err_a_d     = a_q;
                    err_b_d     = b_q;
                    err_r_d     = mul_r;
                end
                if (div_go) state_d = ST_DIV;
                else        advance = 1'b1;
            end
            ST_DIV: if (div_done) begin
                red_sum_d = red_sum_q + quotient;
                advance   = 1'b1;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // B is the inner loop, so the pair counter is {A,B} as one number
        if (advance) begin
            if ((a_q == '1) && (b_q == '1)) begin
                state_d = ST_DONE;
            end else begin
                {a_d, b_d} = {a_q, b_q} + PW'(1);
                state_d    = ST_DRIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_valid_q <= 1'b0;
            err_a_q     <= '0;
            err_b_q     <= '0;
            err_r_q     <= '0;
            err_cnt_q   <= '0;
            over_cnt_q  <= '0;
            ed_sum_q    <= '0;
            max_ed_q    <= '0;
            red_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_valid_q <= err_valid_d;
            err_a_q     <= err_a_d;
            err_b_q     <= err_b_d;
            err_r_q     <= err_r_d;
            err_cnt_q   <= err_cnt_d;
            over_cnt_q  <= over_cnt_d;
            ed_sum_q    <= ed_sum_d;
            max_ed_q    <= max_ed_d;
            red_sum_q   <= red_sum_d;
        end
    end

    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_valid = err_valid_q;
    assign err_a     = err_a_q;
    assign err_b     = err_b_q;
    assign err_r     = err_r_q;
    assign err_cnt   = err_cnt_q;
    assign over_cnt  = over_cnt_q;
    assign ed_sum    = ed_sum_q;
    assign max_ed    = max_ed_q;
    assign red_sum   = red_sum_q;

endmodule

// File: tb/tb_approx_mult_err_sweep.sv
// tb/tb_approx_mult_err_sweep.sv - scoreboard bench for the approximate multiplier error sweep
module tb_approx_mult_err_sweep;
    localparam int W         = 4;
    localparam int RED_W     = 32;
    localparam int RED_SCALE = 10000;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  mul_a, mul_b;
    logic [7:0]    mul_r;
    logic          busy, done, err_valid;
    logic [W-1:0]  err_a, err_b;
    logic [7:0]    err_r;
    logic [8:0]    err_cnt, over_cnt;
    logic [15:0]   ed_sum;
    logic [7:0]    max_ed;
    logic [31:0]   red_sum;

    int            mode;
    logic [7:0]    lut [256];
    logic [7:0]    tb_exact;
    longint        cycle;
    int            checks;
    int            failures;

    typedef struct {
        longint err;
        longint over;
        longint ed;
        longint mx;
        longint red;
        longint cycles;
        longint t0;
    } exp_t;

    exp_t          exp_q[$];
    logic [15:0]   errq[$];

    approx_mult_err_sweep #(.W(W), .RED_SCALE(RED_SCALE), .RED_W(RED_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_r(mul_r), .busy(busy), .done(done), .err_valid(err_valid),
        .err_a(err_a), .err_b(err_b), .err_r(err_r), .err_cnt(err_cnt),
        .over_cnt(over_cnt), .ed_sum(ed_sum), .max_ed(max_ed), .red_sum(red_sum)
    );

    // Multiplier under test: exact, LSB stuck-0, LSB stuck-1, or a random fault table
    assign tb_exact = {4'b0, mul_a} * {4'b0, mul_b};
    always_comb begin
        mul_r = tb_exact;
        case (mode)
            1:       mul_r = tb_exact & 8'hFE;
            2:       mul_r = tb_exact | 8'h01;
            3:       mul_r = lut[{mul_a, mul_b}];
            default: mul_r = tb_exact;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle = cycle + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint req);
        checks = checks + 1;
        if (act != req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int mut(input int m, input int a, input int b);
        int e;
        e = a * b;
        case (m)
            1:       return e & 254;
            2:       return e | 1;
            3:       return int'(lut[a * 16 + b]);
            default: return e;
        endcase
    endfunction

    // Reference: direct evaluation of the metric definitions over all operand pairs
    task automatic model(input int m, input longint t0);
        exp_t x;
        int   ndiv;
        int   e, r, d;
        logic [3:0] a4, b4;
        x = '{0, 0, 0, 0, 0, 0, t0};
        ndiv = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                e = a * b;
                r = mut(m, a, b);
                d = (r > e) ? r - e : e - r;
                if (d != 0) begin
                    x.err++;
                    if (r > e) x.over++;
                    x.ed += d;
                    if (d > x.mx) x.mx = d;
                    a4 = 4'(a);
                    b4 = 4'(b);
                    errq.push_back({a4, b4, 8'(r)});
                    if (e != 0) begin
                        x.red += (longint'(d) * RED_SCALE) / e;
                        ndiv++;
                    end
                end
            end
        end
        x.cycles = 2 * 256 + 1 + longint'(ndiv) * (RED_W + 1);
        exp_q.push_back(x);
    endtask

    int          err_pulses;
    exp_t        mon_x;
    logic [15:0] mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            err_pulses = 0;
        end else begin
            if (err_valid) begin
                err_pulses++;
                if (errq.size() == 0) begin
                    check("unexpected_err_valid", 1, 0);
                end else begin
                    mon_e = errq.pop_front();
                    check("err_trace", {err_a, err_b, err_r}, mon_e);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_x = exp_q.pop_front();
                    check("err_cnt", err_cnt, mon_x.err);
                    check("over_cnt", over_cnt, mon_x.over);
                    check("ed_sum", ed_sum, mon_x.ed);
                    check("max_ed", max_ed, mon_x.mx);
                    check("red_sum", red_sum, mon_x.red);
                    check("done_latency", cycle - mon_x.t0, mon_x.cycles);
                    check("err_valid_pulses", err_pulses, mon_x.err);
                    check("busy_low_at_done", busy, 0);
                end
                err_pulses = 0;
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err_valid"}, err_valid, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_over_cnt"}, over_cnt, 0);
        check({tag, "_ed_sum"}, ed_sum, 0);
        check({tag, "_max_ed"}, max_ed, 0);
        check({tag, "_red_sum"}, red_sum, 0);
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic run_sweep(input int m, input string name);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model(m, cycle);
        check({name, "_busy_after_start"}, busy, 1);
        wait_done(20000, name);
    endtask

    initial begin
        bit hit;
        checks   = 0;
        failures = 0;
        cycle    = 0;
        mode     = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        for (int i = 0; i < 256; i++) lut[i] = 8'((i >> 4) * (i & 15));
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        run_sweep(0, "exact");
        run_sweep(1, "lsb0");
        check("lsb0_err_cnt_64", err_cnt, 64);
        check("lsb0_ed_sum_64", ed_sum, 64);
        run_sweep(2, "lsb1");
        repeat (5) @(negedge clk);
        check("lsb1_hold_err_cnt", err_cnt, 192);
        check("lsb1_hold_over_cnt", over_cnt, 192);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 256; i++) begin
                lut[i] = 8'((i >> 4) * (i & 15));
                if ($urandom_range(0, 3) == 0) lut[i] = lut[i] ^ 8'($urandom_range(1, 255));
            end
            run_sweep(3, "random");
        end

        // Abort a sweep with reset while pair (7,3) is on the multiplier
        @(negedge clk);
        mode  = 2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model(2, cycle);
        void'(exp_q.pop_back());
        hit = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (mul_a == 4'd7 && mul_b == 4'd3) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("abort_pair_timeout", 0, 1);
        #1;
        rst_n = 1'b0;
        errq.delete();
        @(posedge clk);
        #1;
        check_zero("abort");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        check("abort_idle_busy", busy, 0);
        run_sweep(0, "after_abort");
        check("after_abort_err_cnt", err_cnt, 0);

        // start held high, with an extra pulse mid-sweep
        @(negedge clk);
        mode  = 2;
        start = 1'b1;
        @(posedge clk);
        #1;
        model(2, cycle);
        repeat (300) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        wait_done(20000, "held_first");
        model(2, cycle + 1);
        @(posedge clk);
        #1;
        check("held_restart_cleared", err_cnt, 0);
        check("held_restart_busy", busy, 1);
        repeat (200) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20000, "held_second");
        repeat (10) @(negedge clk);
        check("held_no_third_sweep", busy, 0);
        check("pending_expectations", exp_q.size(), 0);
        check("pending_err_trace", errq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
